// File: rtl/lfsr_seq_checker.sv
// Fibonacci LFSR sequence checker. Self-synchronises to an incoming
// generator stream, declares lock after a run of correct predictions, and
// once locked flags/counts every deviating word until a run of consecutive
// errors forces it back to searching.
module lfsr_seq_checker #(
  parameter int unsigned       LENGTH     = 16,
  parameter logic [LENGTH-1:0] TAPS       = LENGTH'(53256),
  parameter int unsigned       LOCK_CNT   = 4,
  parameter int unsigned       UNLOCK_ERR = 3,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [LENGTH-1:0] data,
  output logic              locked,
  output logic              error,
  output logic              lock_lost,
  output logic [CNT_W-1:0]  err_count
);

  typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

  // Run counters are 8 bits: both thresholds are limited to 1..255.
  localparam logic [7:0] LockCnt   = 8'(LOCK_CNT);
  localparam logic [7:0] UnlockErr = 8'(UNLOCK_ERR);

  state_e            state_q, state_d;
  logic [LENGTH-1:0] pred_q, pred_d;
  logic [7:0]        match_cnt_q, match_cnt_d;
  logic [7:0]        err_run_q, err_run_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic              locked_q, locked_d;
  logic              error_q, error_d;
  logic              lock_lost_q, lock_lost_d;
  logic [7:0]        match_inc;
  logic [7:0]        err_run_inc;

  // Same next-state function as the generator: shift left, feedback into bit 0.
  function automatic logic [LENGTH-1:0] next_word(input logic [LENGTH-1:0] w);
    return {w[LENGTH-2:0], ^(w & TAPS)};
  endfunction

  assign match_inc   = match_cnt_q + 8'd1;
  assign err_run_inc = err_run_q + 8'd1;

  // Next-state and registered-output decode for each sampled word.
  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    match_cnt_d = match_cnt_q;
    err_run_d   = err_run_q;
    err_count_d = err_count_q;
    error_d     = 1'b0;
    lock_lost_d = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        StSearch: begin
          // All-zero is the LFSR lockup value and cannot seed a prediction.
          if (data != '0) begin
            pred_d      = next_word(data);
            match_cnt_d = 8'd0;
            state_d     = StVerify;
          end
        end
        StVerify: begin
          if (data == pred_q) begin
            match_cnt_d = match_inc;
            pred_d      = next_word(data);
            if (match_inc == LockCnt) state_d = StLocked;
          end else if (data != '0) begin
            pred_d      = next_word(data);
            match_cnt_d = 8'd0;
          end else begin
            state_d = StSearch;
          end
        end
        StLocked: begin
          // Free-run from our own prediction so corrupted words never leak in.
          pred_d = next_word(pred_q);
          if (data == pred_q) begin
            err_run_d = 8'd0;
          end else begin
            error_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
            if (err_run_inc == UnlockErr) begin
              lock_lost_d = 1'b1;
              state_d     = StSearch;
              err_run_d   = 8'd0;
            end else begin
              err_run_d = err_run_inc;
            end
          end
        end
        default: state_d = StSearch;
      endcase
    end

    locked_d = (state_d == StLocked);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StSearch;
      pred_q      <= '0;
      match_cnt_q <= 8'd0;
      err_run_q   <= 8'd0;
      err_count_q <= '0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      match_cnt_q <= match_cnt_d;
      err_run_q   <= err_run_d;
      err_count_q <= err_count_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign locked    = locked_q;
  assign error     = error_q;
  assign lock_lost = lock_lost_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: directed vector table, hand-written corner
// sequences and a randomized stream checked against a behavioural model.
module tb_lfsr_seq_checker;

  localparam int unsigned LEN  = 16;
  localparam logic [15:0] TAPS = 16'hD008;
  localparam int unsigned LOCK = 4;
  localparam int unsigned ULCK = 3;
  localparam int unsigned CW   = 4;  // small counter so saturation is reachable

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [15:0]   data = '0;
  logic          locked, error, lock_lost;
  logic [CW-1:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  lfsr_seq_checker #(
    .LENGTH    (LEN),
    .TAPS      (TAPS),
    .LOCK_CNT  (LOCK),
    .UNLOCK_ERR(ULCK),
    .CNT_W     (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .data     (data),
    .locked   (locked),
    .error    (error),
    .lock_lost(lock_lost),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural reference: mode 0=search 1=verify 2=locked.
  int          m_mode;
  logic [15:0] m_expect;
  int          m_good, m_bad;
  int          m_errs;
  logic        m_err, m_lost;

  function automatic logic [15:0] nxt(input logic [15:0] w);
    int v;
    v = ((int'(w) * 2) % 65536) + ($countones(w & TAPS) % 2);
    return v[15:0];
  endfunction

  task automatic model_reset();
    m_mode = 0; m_expect = '0; m_good = 0; m_bad = 0; m_errs = 0;
    m_err = 1'b0; m_lost = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [15:0] d);
    m_err  = 1'b0;
    m_lost = 1'b0;
    if (v) begin
      if (m_mode == 0) begin
        if (d != 0) begin m_expect = nxt(d); m_good = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (d == m_expect) begin
          m_good++;
          m_expect = nxt(d);
          if (m_good == LOCK) m_mode = 2;
        end else if (d != 0) begin
          m_expect = nxt(d); m_good = 0;
        end else begin
          m_mode = 0;
        end
      end else begin
        if (d == m_expect) m_bad = 0;
        else begin
          m_err  = 1'b1;
          m_errs = (m_errs + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_errs + 1;
          m_bad++;
          if (m_bad == ULCK) begin m_lost = 1'b1; m_mode = 0; m_bad = 0; end
        end
        m_expect = nxt(m_expect);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return {25'd0, locked, error, lock_lost, err_count};
  endfunction

  function automatic logic [31:0] model_outs();
    logic [CW-1:0] c;
    c = CW'(m_errs);
    return {25'd0, (m_mode == 2), m_err, m_lost, c};
  endfunction

  task automatic send(input logic v, input logic [15:0] d);
    in_valid = v;
    data     = d;
    @(posedge clk);
    #1;
    model_step(v, d);
    check("model", outs(), model_outs());
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("reset_state", outs(), 32'd0);
    rst = 1'b1;
  endtask

  typedef struct packed {
    logic          v;
    logic [15:0]   d;
    logic          lk;
    logic          er;
    logic          ll;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs[$];
  logic [15:0] g;

  initial begin
    // Clean lock, single-bit error, loss of lock, relock after a gap.
    vecs.push_back(vec_t'{1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 4'd0});
    vecs.push_back(vec_t'{1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 4'd0});
    vecs.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0});
    vecs.push_back(vec_t'{1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 4'd0});
    vecs.push_back(vec_t'{1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 4'd0});
    vecs.push_back(vec_t'{1'b1, 16'h0008, 1'b0, 1'b0, 1'b0, 4'd0});
    vecs.push_back(vec_t'{1'b1, 16'h0011, 1'b1, 1'b0, 1'b0, 4'd0});
    vecs.push_back(vec_t'{1'b1, 16'h0022, 1'b1, 1'b0, 1'b0, 4'd0});
    vecs.push_back(vec_t'{1'b1, 16'h0045, 1'b1, 1'b1, 1'b0, 4'd1});
    vecs.push_back(vec_t'{1'b1, 16'h0088, 1'b1, 1'b0, 1'b0, 4'd1});
    vecs.push_back(vec_t'{1'b1, 16'h0111, 1'b1, 1'b0, 1'b0, 4'd1});
    vecs.push_back(vec_t'{1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 4'd2});
    vecs.push_back(vec_t'{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd2});
    vecs.push_back(vec_t'{1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 4'd3});
    vecs.push_back(vec_t'{1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 4'd4});
    vecs.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd4});
    vecs.push_back(vec_t'{1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 4'd4});
    vecs.push_back(vec_t'{1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 4'd4});
    vecs.push_back(vec_t'{1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 4'd4});
    vecs.push_back(vec_t'{1'b1, 16'h0008, 1'b0, 1'b0, 1'b0, 4'd4});
    vecs.push_back(vec_t'{1'b1, 16'h0011, 1'b1, 1'b0, 1'b0, 4'd4});

    do_reset();
    foreach (vecs[i]) begin
      send(vecs[i].v, vecs[i].d);
      check($sformatf("vec%0d", i), outs(),
            {25'd0, vecs[i].lk, vecs[i].er, vecs[i].ll, vecs[i].cnt});
    end

    // Zero words: ignored in search, abort verify back to search.
    do_reset();
    for (int i = 0; i < 3; i++) send(1'b1, 16'h0000);
    check("zero_search_locked", {31'd0, locked}, 32'd0);
    send(1'b1, 16'h0001);
    send(1'b1, 16'h0002);
    send(1'b1, 16'h0004);
    send(1'b1, 16'h0000);
    send(1'b1, 16'h0008);
    send(1'b1, 16'h0011);
    send(1'b1, 16'h0022);
    send(1'b1, 16'h0044);
    check("zero_verify_not_yet", {31'd0, locked}, 32'd0);
    send(1'b1, 16'h0088);
    check("zero_verify_relock", {31'd0, locked}, 32'd1);

    // Async reset mid-cycle while locked with err_count=3 and error high.
    do_reset();
    g = 16'h0001;
    for (int i = 0; i < 5; i++) begin send(1'b1, g); g = nxt(g); end
    for (int i = 0; i < 3; i++) begin
      send(1'b1, g ^ 16'h8000); g = nxt(g);
      if (i < 2) begin send(1'b1, g); g = nxt(g); end
    end
    check("pre_reset", outs(), {25'd0, 1'b1, 1'b1, 1'b0, 4'd3});
    #3 rst = 1'b0;
    #1 check("async_reset", outs(), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    g = 16'h0100;
    for (int i = 0; i < 4; i++) begin send(1'b1, g); g = nxt(g); end
    check("relock_not_yet", {31'd0, locked}, 32'd0);
    send(1'b1, g); g = nxt(g);
    check("relock_after_5", {31'd0, locked}, 32'd1);

    // Error counter saturation: alternate bad/good words while locked.
    for (int i = 0; i < 17; i++) begin
      send(1'b1, g ^ 16'h0001); g = nxt(g);
      send(1'b1, g); g = nxt(g);
    end
    check("saturate", outs(), {25'd0, 1'b1, 1'b0, 1'b0, 4'hF});

    // Randomized stream: gaps, bit flips, zeros, error bursts, reseeds.
    do_reset();
    g = 16'hACE1;
    begin
      int burst;
      burst = 0;
      for (int n = 0; n < 3000; n++) begin
        logic v;
        logic [15:0] d;
        int r;
        v = ($urandom % 4) != 0;
        r = int'($urandom % 100);
        if ($urandom % 150 == 0) burst = int'($urandom_range(2, 4));
        if ($urandom % 400 == 0) g = 16'($urandom_range(1, 65535));
        if (burst > 0) d = ~g;
        else if (r < 6) d = g ^ (16'd1 << ($urandom % 16));
        else if (r < 8) d = 16'h0000;
        else if (r < 10) d = 16'($urandom);
        else d = g;
        send(v, d);
        if (v) begin
          g = nxt(g);
          if (burst > 0) burst--;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_checker.md
Name: lfsr_seq_checker

Overview:
- Downstream consumer of the Fibonacci LFSR pattern generator.
- Samples each generated word, self-synchronises to the sequence and declares lock after a run of correct predictions.
- Once locked, flags and counts every word that deviates from the predicted sequence. Declares loss of lock after a run of consecutive errors.
- Used as the on-chip/bench checker for PRBS links and LFSR regression.

Parameters:
- LENGTH, 16, word width; must match the generator.
- TAPS, 53256 (16'hD008), feedback tap mask; bit i set means data[i] participates in the feedback XOR.
- LOCK_CNT, 4, consecutive correct predictions required to enter LOCKED (1..255).
- UNLOCK_ERR, 3, consecutive mismatches in LOCKED that force loss of lock (1..255).
- CNT_W, 16, width of the error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  data is a valid generator word this cycle.
- data  in  LENGTH  word from the LFSR.
- locked  out  1  checker is in LOCKED.
- error  out  1  one-cycle pulse: a word checked in LOCKED mismatched.
- lock_lost  out  1  one-cycle pulse: transition LOCKED->SEARCH.
- err_count  out  CNT_W  total mismatches since reset; saturates at all-ones.

Behaviour:
- Next-state function (decided, identical to generator): next(w) = {w[LENGTH-2:0], ^(w & TAPS)}.
- Reset (rst=0, async): state=SEARCH, predictor=0, match_cnt=0, err_run=0. Outputs locked=0, error=0, lock_lost=0, err_count=0.
- All state and outputs are registered. Every effect of a valid word is visible the cycle after the edge that samples it.
- in_valid=0: no state change. error and lock_lost drop to 0.
- SEARCH:
  - Valid all-zero word (LFSR lockup value) is ignored; stay in SEARCH.
  - Valid non-zero word: predictor<=next(data), match_cnt<=0, go to VERIFY.
- VERIFY:
  - Valid data==predictor: match_cnt++, predictor<=next(data). If match_cnt+1==LOCK_CNT, go to LOCKED and set locked=1.
  - Valid data!=predictor: re-seed. If data is non-zero, predictor<=next(data) and match_cnt<=0, stay in VERIFY. If data is zero, go to SEARCH.
  - No error pulse and no err_count change in SEARCH or VERIFY.
- LOCKED:
  - Predictor always advances from itself: predictor<=next(predictor). A corrupted word never corrupts the prediction.
  - Match: err_run<=0.
  - Mismatch: error=1 for one cycle, err_count++ (saturating), err_run++.
  - If err_run+1==UNLOCK_ERR: lock_lost=1 for one cycle, locked<=0, state<=SEARCH, err_run<=0. The same word produces both error and lock_lost.
- err_count holds at 2^CNT_W-1 once reached. It is never cleared except by reset.
- Reset asserted mid-operation clears everything immediately, regardless of in_valid.

Test Plan:
- Clean sequence: LOCK_CNT=4, words 0x0001,0x0002,0x0004,0x0008,0x0011,0x0022,0x0044,0x0088,0x0111 back-to-back -> locked=1 the cycle after 0x0011 is sampled; error never pulses; err_count=0.
- Single bit error while locked: send 0x0045 in place of 0x0044, then 0x0088, 0x0111 -> exactly one error pulse; err_count=1; locked stays 1; 0x0088 and 0x0111 match.
- Loss of lock: UNLOCK_ERR=3, three consecutive 0xFFFF words while locked -> three error pulses; lock_lost pulses with the third; locked=0; err_count=3. Resuming the true sequence relocks after 5 valid words.
- Lockup/zero handling: 0x0000 words in SEARCH -> stay in SEARCH, locked=0. A 0x0000 word in VERIFY -> return to SEARCH.
- Valid gaps: toggle in_valid 1/0 on the clean sequence -> same lock point counted in valid words; no pulses during gaps.
- Async reset while locked with err_count=3: drop rst mid-cycle -> locked, err_count and pulses go to 0 before the next edge; relock requires a full LOCK_CNT+1 valid words.
